// File: rtl/orbit_nbody_engine_if.sv
// Host-side bundle for the orbit integrator: step control,
// state initialisation and per-body pixel readout.
interface orbit_nbody_engine_if #(
    parameter int W        = 32,
    parameter int N_BODIES = 4,
    parameter int IDXW     = 2
);
    logic                step_req;
    logic                step_busy;
    logic                step_done;
    logic                step_overrun;
    logic                init_we;
    logic [IDXW-1:0]     init_idx;
    logic [1:0]          init_sel;
    logic [W-1:0]        init_data;
    logic [N_BODIES-1:0] crashed;
    logic [IDXW-1:0]     rd_idx;
    logic [9:0]          rd_px;
    logic [9:0]          rd_py;
    logic                rd_vis;

    modport master (
        output step_req, init_we, init_idx, init_sel,
        output init_data, rd_idx,
        input  step_busy, step_done, step_overrun,
        input  crashed, rd_px, rd_py, rd_vis
    );

    modport slave (
        input  step_req, init_we, init_idx, init_sel,
        input  init_data, rd_idx,
        output step_busy, step_done, step_overrun,
        output crashed, rd_px, rd_py, rd_vis
    );
endinterface

// File: rtl/orbit_nbody_engine.sv
// Time-multiplexed Euler-Cromer orbit integrator for N bodies
// around one central mass, with registered VGA pixel readout.
module orbit_nbody_engine #(
    parameter int          W         = 32,
    parameter int          N_BODIES  = 4,
    parameter int unsigned GM        = 1000,
    parameter int          ACC_FRAC  = 16,
    parameter int          DT_SHIFT  = 0,
    parameter int          RMIN      = 8,
    parameter int          PIX_SHIFT = 0,
    parameter int          X_OFF     = 320,
    parameter int          Y_OFF     = 240
) (
    input logic                  CLOCK_50,
    input logic                  reset_n,
    orbit_nbody_engine_if.slave  bus
);
    localparam int IDXW = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
    localparam int CW   = $clog2(2 * W) + 1;

    localparam logic [2*W-1:0] RMIN2   = (2*W)'(RMIN * RMIN);
    localparam logic [2*W-1:0] DIV_NUM = (2*W)'(GM) << ACC_FRAC;
    localparam logic [2*W-1:0] QMAX    =
        {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [W+1:0] XOFF_S = (W+2)'(X_OFF);
    localparam logic signed [W+1:0] YOFF_S = (W+2)'(Y_OFF);
    localparam logic signed [W+1:0] XLIM   = (W+2)'(640);
    localparam logic signed [W+1:0] YLIM   = (W+2)'(480);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_RSQ, S_SQRT, S_CUBE,
        S_DIV, S_ACCEL, S_UPDATE, S_DONE
    } state_t;

    state_t state;

    logic signed [W-1:0] pos_x [N_BODIES];
    logic signed [W-1:0] pos_y [N_BODIES];
    logic signed [W-1:0] vel_x [N_BODIES];
    logic signed [W-1:0] vel_y [N_BODIES];
    logic [N_BODIES-1:0] crashed_r;

    logic [IDXW-1:0]     idx;
    logic signed [W-1:0] cx, cy, cvx, cvy, ax, ay;
    logic [2*W-1:0]      r2, rad;
    logic [W+1:0]        rem_s;
    logic [W-1:0]        root;
    logic [3*W-1:0]      r3;
    logic [3*W-1:0]      rem_d;
    logic [2*W-1:0]      num, quo;
    logic [CW-1:0]       cnt;
    logic                busy_r, done_r, ovr_r;

    logic signed [2*W-1:0] xe, ye, qe;
    logic signed [2*W-1:0] prod_x, prod_y, sh_x, sh_y;
    logic [2*W-1:0]        r2_calc;
    logic [W+3:0]          s_rem, s_trial;
    logic                  s_ge;
    logic [3*W:0]          d_rem;
    logic                  d_ge;
    logic [3*W-1:0]        r3_calc;
    logic [W-1:0]          qc;
    logic signed [W-1:0]   ax_calc, ay_calc;
    logic signed [W-1:0]   nvx, nvy, nx, ny;
    logic                  last;

    always_comb begin
        xe      = {{W{cx[W-1]}}, cx};
        ye      = {{W{cy[W-1]}}, cy};
        r2_calc = $unsigned(xe * xe) + $unsigned(ye * ye);

        s_rem   = {rem_s, rad[2*W-1 -: 2]};
        s_trial = {2'b00, root, 2'b01};
        s_ge    = (s_rem >= s_trial);

        d_rem   = {rem_d, num[2*W-1]};
        d_ge    = (d_rem >= {1'b0, r3});

        r3_calc = {{W{1'b0}}, r2} * {{(2*W){1'b0}}, root};

        qc      = (quo > QMAX) ? QMAX[W-1:0] : quo[W-1:0];
        qe      = {{W{1'b0}}, qc};
        prod_x  = -(xe * qe);
        prod_y  = -(ye * qe);
        sh_x    = prod_x >>> ACC_FRAC;
        sh_y    = prod_y >>> ACC_FRAC;
        ax_calc = W'(sh_x);
        ay_calc = W'(sh_y);

        // Euler-Cromer: position uses the freshly updated velocity
        nvx  = cvx + (ax >>> DT_SHIFT);
        nvy  = cvy + (ay >>> DT_SHIFT);
        nx   = cx + (nvx >>> DT_SHIFT);
        ny   = cy + (nvy >>> DT_SHIFT);
        last = (idx == IDXW'(N_BODIES - 1));
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ovr_r     <= 1'b0;
            crashed_r <= '1;
            idx       <= '0;
            for (int i = 0; i < N_BODIES; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                vel_x[i] <= '0;
                vel_y[i] <= '0;
            end
            cx    <= '0;
            cy    <= '0;
            cvx   <= '0;
            cvy   <= '0;
            ax    <= '0;
            ay    <= '0;
            r2    <= '0;
            rad   <= '0;
            rem_s <= '0;
            root  <= '0;
            r3    <= '0;
            rem_d <= '0;
            num   <= '0;
            quo   <= '0;
            cnt   <= '0;
        end else begin
            ovr_r  <= bus.step_req && (state != S_IDLE);
            done_r <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.init_we) begin
                        unique case (bus.init_sel)
                            2'd0: pos_x[bus.init_idx] <= bus.init_data;
                            2'd1: pos_y[bus.init_idx] <= bus.init_data;
                            2'd2: vel_x[bus.init_idx] <= bus.init_data;
                            2'd3: vel_y[bus.init_idx] <= bus.init_data;
                        endcase
                        crashed_r[bus.init_idx] <= 1'b0;
                    end
                    if (bus.step_req) begin
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (crashed_r[idx]) begin
                        if (last) begin
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end else begin
                        cx    <= pos_x[idx];
                        cy    <= pos_y[idx];
                        cvx   <= vel_x[idx];
                        cvy   <= vel_y[idx];
                        state <= S_RSQ;
                    end
                end
                S_RSQ: begin
                    if (r2_calc < RMIN2) begin
                        crashed_r[idx] <= 1'b1;
                        if (last) begin
                            done_r <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end else begin
                        r2    <= r2_calc;
                        rad   <= r2_calc;
                        rem_s <= '0;
                        root  <= '0;
                        cnt   <= CW'(W - 1);
                        state <= S_SQRT;
                    end
                end
                S_SQRT: begin
                    rem_s <= (W+2)'(s_ge ? s_rem - s_trial : s_rem);
                    root  <= {root[W-2:0], s_ge};
                    rad   <= rad << 2;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) state <= S_CUBE;
                end
                S_CUBE: begin
                    r3    <= r3_calc;
                    num   <= DIV_NUM;
                    quo   <= '0;
                    rem_d <= '0;
                    cnt   <= CW'(2 * W - 1);
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem_d <= (3*W)'(d_ge ? d_rem - {1'b0, r3} : d_rem);
                    quo   <= {quo[2*W-2:0], d_ge};
                    num   <= num << 1;
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) state <= S_ACCEL;
                end
                S_ACCEL: begin
                    ax    <= ax_calc;
                    ay    <= ay_calc;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    vel_x[idx] <= nvx;
                    vel_y[idx] <= nvy;
                    pos_x[idx] <= nx;
                    pos_y[idx] <= ny;
                    if (last) begin
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic signed [W-1:0] rx, ry;
    logic signed [W+1:0] rxe, rye, sx, sy;
    logic                vis_calc;

    always_comb begin
        rx  = pos_x[bus.rd_idx];
        ry  = pos_y[bus.rd_idx];
        rxe = {{2{rx[W-1]}}, rx};
        rye = {{2{ry[W-1]}}, ry};
        sx  = (rxe >>> PIX_SHIFT) + XOFF_S;
        sy  = (rye >>> PIX_SHIFT) + YOFF_S;
        vis_calc = !crashed_r[bus.rd_idx] &&
                   !sx[W+1] && (sx < XLIM) &&
                   !sy[W+1] && (sy < YLIM);
    end

    logic [9:0] px_r, py_r;
    logic       vis_r;

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            px_r  <= '0;
            py_r  <= '0;
            vis_r <= 1'b0;
        end else begin
            px_r  <= sx[9:0];
            py_r  <= sy[9:0];
            vis_r <= vis_calc;
        end
    end

    assign bus.step_busy    = busy_r;
    assign bus.step_done    = done_r;
    assign bus.step_overrun = ovr_r;
    assign bus.crashed      = crashed_r;
    assign bus.rd_px        = px_r;
    assign bus.rd_py        = py_r;
    assign bus.rd_vis       = vis_r;
endmodule
